// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-port fixed-latency SRAM
// Data side wins arbitration; every access runs IDLE -> ACCESS x N -> DONE.
module mem_port_arbiter #(
  parameter int ACCESS_CYCLES = 4,
  parameter int ADDR_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  output logic              if_busy,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic [1:0]        grant,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_we,
  input  logic [31:0]       sram_rdata
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mem_req;
  logic             unused_addr_bits;

  assign mem_req  = mem_rd_en | mem_wr_en;
  assign if_busy  = if_req & ~if_ready;
  assign mem_busy = mem_req & ~mem_ready;

  // Byte-offset and high address bits are not part of the SRAM word address.
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      grant      <= 2'b00;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            grant      <= 2'b10;
            sram_addr  <= mem_addr[ADDR_W+1:2];
            sram_wdata <= mem_wdata;
            sram_we    <= mem_wr_en;
            cnt        <= CNT_LOAD;
            state      <= ACCESS;
          end else if (if_req) begin
            grant     <= 2'b01;
            sram_addr <= if_addr[ADDR_W+1:2];
            sram_we   <= 1'b0;
            cnt       <= CNT_LOAD;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (grant[0]) begin
              if_rdata <= sram_rdata;
              if_ready <= 1'b1;
            end else begin
              // A store leaves the load-data register untouched.
              if (!sram_we) mem_rdata <= sram_rdata;
              mem_ready <= 1'b1;
            end
            sram_we <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // Always pass through IDLE so a just-served requester can drop its request.
          if_ready  <= 1'b0;
          mem_ready <= 1'b0;
          grant     <= 2'b00;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
